// File: rtl/wireframe_buffer.sv
// 1-bit-per-pixel wireframe frame store: self-clear, accept rasterizer writes, then
// stream the frame out in raster order over a valid/ready port.
module wireframe_buffer #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned HEIGHT    = 24,
   parameter int unsigned ADDR_SIZE = 10,
   parameter bit          BG        = 1'b1
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      write_en,
   input  logic [ADDR_SIZE-1:0]      addr,
   input  logic                      wf_data,
   input  logic                      done,
   output logic                      cf_ready,
   output logic                      pix_valid,
   input  logic                      pix_ready,
   output logic                      pix_data,
   output logic [$clog2(WIDTH)-1:0]  pix_x,
   output logic [$clog2(HEIGHT)-1:0] pix_y,
   output logic                      pix_eol,
   output logic                      pix_last,
   output logic                      wr_err,
   output logic [7:0]                frame_count
);

   localparam int unsigned NumPix = WIDTH * HEIGHT;
   localparam int unsigned XW     = $clog2(WIDTH);
   localparam int unsigned YW     = $clog2(HEIGHT);

   localparam logic [ADDR_SIZE:0]   PixEnd  = (ADDR_SIZE + 1)'(NumPix);
   localparam logic [ADDR_SIZE-1:0] PixLast = ADDR_SIZE'(NumPix - 1);
   localparam logic [XW-1:0]        XLast   = XW'(WIDTH - 1);

   typedef enum logic [1:0] {StClear, StDraw, StScan} state_e;

   state_e                state_q, state_d;
   logic [ADDR_SIZE-1:0]  cnt_q, cnt_d;
   logic [ADDR_SIZE-1:0]  rp_q, rp_d;
   logic [XW-1:0]         fx_q, fx_d;
   logic [YW-1:0]         fy_q, fy_d;
   logic                  pix_valid_q, pix_valid_d;
   logic                  pix_data_q, pix_data_d;
   logic [XW-1:0]         pix_x_q, pix_x_d;
   logic [YW-1:0]         pix_y_q, pix_y_d;
   logic                  pix_eol_q, pix_eol_d;
   logic                  pix_last_q, pix_last_d;
   logic                  wr_err_q, wr_err_d;
   logic [7:0]            frame_count_q, frame_count_d;
   logic                  addr_ok;
   logic                  last_xfer;

   logic mem [NumPix];

   assign addr_ok   = {1'b0, addr} < PixEnd;
   assign last_xfer = pix_valid_q && pix_ready && pix_last_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rp_d          = rp_q;
      fx_d          = fx_q;
      fy_d          = fy_q;
      pix_valid_d   = pix_valid_q;
      pix_data_d    = pix_data_q;
      pix_x_d       = pix_x_q;
      pix_y_d       = pix_y_q;
      pix_eol_d     = pix_eol_q;
      pix_last_d    = pix_last_q;
      wr_err_d      = wr_err_q;
      frame_count_d = frame_count_q;

      unique case (state_q)
         StClear: begin
            if (write_en) wr_err_d = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == PixLast) begin
               state_d = StDraw;
               cnt_d   = '0;
            end
         end
         StDraw: begin
            if (write_en && !addr_ok) wr_err_d = 1'b1;
            if (done) begin
               state_d = StScan;
               rp_d    = '0;
               fx_d    = '0;
               fy_d    = '0;
            end
         end
         StScan: begin
            if (write_en) wr_err_d = 1'b1;
            if (last_xfer) begin
               pix_valid_d   = 1'b0;
               frame_count_d = frame_count_q + 8'd1;
               state_d       = StClear;
               cnt_d         = '0;
            end else if (pix_ready || !pix_valid_q) begin
               // Output slot is free (empty or draining this edge): fetch pixel rp.
               pix_valid_d = 1'b1;
               pix_data_d  = mem[rp_q];
               pix_x_d     = fx_q;
               pix_y_d     = fy_q;
               pix_eol_d   = (fx_q == XLast);
               pix_last_d  = (rp_q == PixLast);
               rp_d        = rp_q + 1'b1;
               if (fx_q == XLast) begin
                  fx_d = '0;
                  fy_d = fy_q + 1'b1;
               end else begin
                  fx_d = fx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = StClear;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q       <= StClear;
         cnt_q         <= '0;
         rp_q          <= '0;
         fx_q          <= '0;
         fy_q          <= '0;
         pix_valid_q   <= 1'b0;
         pix_data_q    <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_eol_q     <= 1'b0;
         pix_last_q    <= 1'b0;
         wr_err_q      <= 1'b0;
         frame_count_q <= 8'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rp_q          <= rp_d;
         fx_q          <= fx_d;
         fy_q          <= fy_d;
         pix_valid_q   <= pix_valid_d;
         pix_data_q    <= pix_data_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_eol_q     <= pix_eol_d;
         pix_last_q    <= pix_last_d;
         wr_err_q      <= wr_err_d;
         frame_count_q <= frame_count_d;
      end
   end

   // Pixel store is never reset; the CLEAR sweep initialises it.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         if (state_q == StClear) begin
            mem[cnt_q] <= BG;
         end else if (state_q == StDraw && write_en && addr_ok) begin
            mem[addr] <= wf_data;
         end
      end
   end

   assign cf_ready    = (state_q == StDraw);
   assign pix_valid   = pix_valid_q;
   assign pix_data    = pix_data_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_eol     = pix_eol_q;
   assign pix_last    = pix_last_q;
   assign wr_err      = wr_err_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_wireframe_buffer.sv
// Scoreboard bench for wireframe_buffer: a pixel-image model queues expected beats on each
// done pulse, and a negedge monitor pops and compares every transferred beat.
module tb_wireframe_buffer;

   localparam int WIDTH     = 32;
   localparam int HEIGHT    = 24;
   localparam int ADDR_SIZE = 10;
   localparam int N         = WIDTH * HEIGHT;
   localparam bit BG        = 1'b1;
   localparam int XW        = $clog2(WIDTH);
   localparam int YW        = $clog2(HEIGHT);

   typedef struct packed {
      logic          d;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic          eol;
      logic          last;
   } beat_t;

   logic                 tb_clk = 1'b0;
   logic                 n_rst, write_en, wf_data, done, pix_ready;
   logic [ADDR_SIZE-1:0] addr;
   logic                 cf_ready, pix_valid, pix_data, pix_eol, pix_last, wr_err;
   logic [XW-1:0]        pix_x;
   logic [YW-1:0]        pix_y;
   logic [7:0]           frame_count;

   always #5 tb_clk = ~tb_clk;

   wireframe_buffer #(
      .WIDTH     (WIDTH),
      .HEIGHT    (HEIGHT),
      .ADDR_SIZE (ADDR_SIZE),
      .BG        (BG)
   ) dut (
      .clk         (tb_clk),
      .n_rst       (n_rst),
      .write_en    (write_en),
      .addr        (addr),
      .wf_data     (wf_data),
      .done        (done),
      .cf_ready    (cf_ready),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_data    (pix_data),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_eol     (pix_eol),
      .pix_last    (pix_last),
      .wr_err      (wr_err),
      .frame_count (frame_count)
   );

   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   int    frames_seen = 0;
   int    last_cyc = 0;
   int    beat_idx = 0;
   int    done_edge = 0;
   int    exp_fc = 0;
   bit    ready_rand = 1'b0;
   bit    img [N];
   beat_t exp_q [$];

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge tb_clk);
      cyc++;
   end

   initial forever begin
      @(posedge tb_clk);
      #1;
      pix_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: a beat transfers on the next rising edge when valid && ready here.
   initial begin
      beat_t cur, prev_out, e;
      bit    prev_stall;
      prev_stall = 1'b0;
      prev_out   = '0;
      forever begin
         @(negedge tb_clk);
         cur = {pix_data, pix_x, pix_y, pix_eol, pix_last};
         if (n_rst && prev_stall) check("stall_hold", {pix_valid, cur}, {1'b1, prev_out});
         if (n_rst && pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_beat", pix_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("beat%0d{d,x,y,eol,last}", beat_idx), cur, e);
               beat_idx++;
               if (e.last) begin
                  frames_seen++;
                  last_cyc = cyc;
                  beat_idx = 0;
               end
            end
         end
         prev_stall = n_rst && pix_valid && !pix_ready;
         prev_out   = cur;
      end
   end

   task automatic img_clear();
      for (int i = 0; i < N; i++) img[i] = BG;
   endtask

   task automatic push_frame();
      beat_t b;
      for (int i = 0; i < N; i++) begin
         b.d    = img[i];
         b.x    = XW'(i % WIDTH);
         b.y    = YW'(i / WIDTH);
         b.eol  = (i % WIDTH) == WIDTH - 1;
         b.last = (i == N - 1);
         exp_q.push_back(b);
      end
      img_clear();
   endtask

   task automatic do_reset();
      n_rst    = 1'b0;
      write_en = 1'b0;
      done     = 1'b0;
      exp_q.delete();
      beat_idx = 0;
      exp_fc   = 0;
      img_clear();
      @(posedge tb_clk);
      #1;
      check("rst_valid_next_edge", pix_valid, 0);
      @(posedge tb_clk);
      #1;
      check("rst_cf_ready", cf_ready, 0);
      check("rst_pix_data", pix_data, 0);
      check("rst_pix_x", pix_x, 0);
      check("rst_pix_y", pix_y, 0);
      check("rst_pix_eol", pix_eol, 0);
      check("rst_pix_last", pix_last, 0);
      check("rst_wr_err", wr_err, 0);
      check("rst_frame_count", frame_count, 0);
      n_rst = 1'b1;
   endtask

   // Counts edges from reset release until cf_ready; optionally writes during CLEAR.
   task automatic measure_clear(input int pulse_at);
      int n;
      n = 0;
      while (!cf_ready && n < 2000) begin
         write_en = (n == pulse_at);
         addr     = 10'd3;
         wf_data  = 1'b0;
         @(posedge tb_clk);
         #1;
         n++;
      end
      write_en = 1'b0;
      check("clear_latency", n, N);
   endtask

   task automatic wr(input int a, input bit d, input bit model);
      write_en = 1'b1;
      addr     = ADDR_SIZE'(a);
      wf_data  = d;
      @(posedge tb_clk);
      #1;
      write_en = 1'b0;
      if (model && a < N) img[a] = d;
   endtask

   task automatic pulse_done();
      push_frame();
      done = 1'b1;
      @(posedge tb_clk);
      #1;
      done      = 1'b0;
      write_en  = 1'b0;
      done_edge = cyc;
      check("cf_ready_drop", cf_ready, 0);
   endtask

   task automatic wait_frame(input int target, input bit timed);
      int n;
      n = 0;
      while (frames_seen < target && n < 5000) begin
         @(posedge tb_clk);
         #1;
         n++;
      end
      check("frame_done", frames_seen, target);
      check("valid_drop", pix_valid, 0);
      exp_fc = (exp_fc + 1) % 256;
      check("frame_count", frame_count, exp_fc);
      if (timed) check("scan_cycles", last_cyc + 1 - done_edge, N + 1);
      n = 0;
      while (!cf_ready && n < 2000) begin
         @(posedge tb_clk);
         #1;
         n++;
      end
      check("reclear_latency", cyc - (last_cyc + 1), N);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      int a;
      n_rst     = 1'b0;
      write_en  = 1'b0;
      addr      = '0;
      wf_data   = 1'b0;
      done      = 1'b0;
      pix_ready = 1'b1;

      do_reset();
      measure_clear(-1);
      check("post_clear_wr_err", wr_err, 0);
      check("post_clear_frame_count", frame_count, 0);

      // Three dark pixels, full-rate scanout.
      wr(0, 1'b0, 1'b1);
      wr(33, 1'b0, 1'b1);
      wr(767, 1'b0, 1'b1);
      pulse_done();
      wait_frame(1, 1'b1);

      // Same image under random backpressure.
      ready_rand = 1'b1;
      wr(0, 1'b0, 1'b1);
      wr(33, 1'b0, 1'b1);
      wr(767, 1'b0, 1'b1);
      pulse_done();
      wait_frame(2, 1'b0);

      // Random image with repeated addresses, still under backpressure.
      for (int i = 0; i < 40; i++) begin
         a = $urandom_range(0, N - 1);
         wr(a, 1'($urandom_range(0, 1)), 1'b1);
         if (i % 8 == 0) begin
            wr(a, 1'b0, 1'b1);
            wr(a, 1'b1, 1'b1);
         end
      end
      pulse_done();
      wait_frame(3, 1'b0);
      ready_rand = 1'b0;
      check("no_drop_wr_err", wr_err, 0);

      // Out-of-range draw write, then a write during scan.
      wr(800, 1'b0, 1'b1);
      check("wr_err_oob", wr_err, 1);
      wr(40, 1'b0, 1'b1);
      pulse_done();
      repeat (3) begin
         @(posedge tb_clk);
         #1;
      end
      wr(10, 1'b0, 1'b0);
      check("wr_err_scan", wr_err, 1);
      wait_frame(4, 1'b1);
      pulse_done();
      wait_frame(5, 1'b1);
      check("wr_err_sticky", wr_err, 1);

      // Write coincident with done is committed.
      write_en = 1'b1;
      addr     = 10'd5;
      wf_data  = 1'b0;
      img[5]   = 1'b0;
      pulse_done();
      wait_frame(6, 1'b1);

      // Reset at beat 100 of a scan.
      for (int i = 0; i < 10; i++) wr($urandom_range(0, N - 1), 1'b0, 1'b1);
      pulse_done();
      a = 0;
      while (beat_idx < 100 && a < 2000) begin
         @(posedge tb_clk);
         #1;
         a++;
      end
      check("reached_beat100", beat_idx, 100);
      do_reset();
      measure_clear(5);
      check("wr_err_clear", wr_err, 1);
      pulse_done();
      wait_frame(7, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
